// File: rtl/cache_repl_fifo.sv
// Per-set FIFO (optionally LRU) victim selector driven by saturating per-way age counters.
// Optional feature: define CACHE_REPL_LRU_EN so that read hits re-age a way (LRU instead of FIFO).
module cache_repl_fifo #(
  parameter int SETS  = 4,
  parameter int WAYS  = 4,
  parameter int CNT_W = 8,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_vld,
  input  logic [SET_W-1:0] lookup_set,
  input  logic             fill_vld,
  input  logic [SET_W-1:0] fill_set,
  input  logic [WAY_W-1:0] fill_way,
  input  logic             hit_vld,
  input  logic [SET_W-1:0] hit_set,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             flush,
  output logic             victim_vld,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_inv
);

  logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0][CNT_W-1:0] age_q, age_d;
  logic             victim_vld_q, victim_vld_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;
  logic             victim_inv_q, victim_inv_d;

`ifndef CACHE_REPL_LRU_EN
  // Hit ports exist for interface compatibility but carry no meaning under FIFO policy.
  logic unused_hit;
  assign unused_hit = ^{hit_vld, hit_set, hit_way};
`endif

  // Flush wins over everything, fill wins over hit; valid ways otherwise age by one.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    if (flush) begin
      valid_d = '0;
      age_d   = '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          if (fill_vld && fill_set == SET_W'(s) && fill_way == WAY_W'(w)) begin
            valid_d[s][w] = 1'b1;
            age_d[s][w]   = '0;
          end
`ifdef CACHE_REPL_LRU_EN
          else if (hit_vld && hit_set == SET_W'(s) && hit_way == WAY_W'(w) && valid_q[s][w]) begin
            age_d[s][w] = '0;
          end
`endif
          else if (valid_q[s][w] && age_q[s][w] != '1) begin
            age_d[s][w] = age_q[s][w] + 1'b1;
          end
        end
      end
    end
  end

  // Victim is chosen from pre-edge state, so same-cycle updates never affect it.
  logic             found_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] best_way;
  logic [CNT_W-1:0] best_age;

  always_comb begin
    found_inv = 1'b0;
    inv_way   = '0;
    best_way  = '0;
    best_age  = age_q[lookup_set][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[lookup_set][w]) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    // Strict greater-than keeps ties on the lowest index.
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[lookup_set][w] > best_age) begin
        best_age = age_q[lookup_set][w];
        best_way = WAY_W'(w);
      end
    end
    victim_vld_d = lookup_vld;
    victim_way_d = victim_way_q;
    victim_inv_d = victim_inv_q;
    if (lookup_vld) begin
      victim_way_d = found_inv ? inv_way : best_way;
      victim_inv_d = found_inv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      age_q        <= '0;
      victim_vld_q <= 1'b0;
      victim_way_q <= '0;
      victim_inv_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      age_q        <= age_d;
      victim_vld_q <= victim_vld_d;
      victim_way_q <= victim_way_d;
      victim_inv_q <= victim_inv_d;
    end
  end

  assign victim_vld = victim_vld_q;
  assign victim_way = victim_way_q;
  assign victim_inv = victim_inv_q;

endmodule

// File: tb/tb_cache_repl_fifo.sv
// Bench for cache_repl_fifo: directed scenarios plus random traffic against an age/valid reference model.
// Result ports: victim_vld is a one-cycle pulse per lookup; way/inv hold between pulses.
module tb_cache_repl_fifo;

  localparam int SETS = 4;
  localparam int WAYS = 4;
  localparam int MAXA = 255;

`ifdef CACHE_REPL_LRU_EN
  localparam bit LRU = 1'b1;
`else
  localparam bit LRU = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lookup_vld = 1'b0;
  logic [1:0] lookup_set = '0;
  logic       fill_vld = 1'b0;
  logic [1:0] fill_set = '0;
  logic [1:0] fill_way = '0;
  logic       hit_vld = 1'b0;
  logic [1:0] hit_set = '0;
  logic [1:0] hit_way = '0;
  logic       flush = 1'b0;
  logic       victim_vld;
  logic [1:0] victim_way;
  logic       victim_inv;

  always #5 clk = ~clk;

  cache_repl_fifo #(.SETS(SETS), .WAYS(WAYS), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_vld(lookup_vld), .lookup_set(lookup_set),
    .fill_vld(fill_vld), .fill_set(fill_set), .fill_way(fill_way),
    .hit_vld(hit_vld), .hit_set(hit_set), .hit_way(hit_way),
    .flush(flush),
    .victim_vld(victim_vld), .victim_way(victim_way), .victim_inv(victim_inv)
  );

  // reference model and scoreboard
  bit         mv[SETS][WAYS];
  int         ma[SETS][WAYS];
  logic [2:0] exp_q[$];
  logic [2:0] held;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 1'b0;
        ma[s][w] = 0;
      end
    exp_q.delete();
    held = '0;
  endtask

  // Free slot first, otherwise oldest line, earliest way on equal age.
  function automatic logic [2:0] model_victim(input int s);
    int oldest = -1;
    int pick = 0;
    for (int w = 0; w < WAYS; w++)
      if (!mv[s][w]) return {1'b1, 2'(w)};
    for (int w = 0; w < WAYS; w++)
      if (ma[s][w] > oldest) begin
        oldest = ma[s][w];
        pick = w;
      end
    return {1'b0, 2'(pick)};
  endfunction

  task automatic model_update();
    if (flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          mv[s][w] = 1'b0;
          ma[s][w] = 0;
        end
      return;
    end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (fill_vld && int'(fill_set) == s && int'(fill_way) == w) begin
          mv[s][w] = 1'b1;
          ma[s][w] = 0;
        end else if (LRU && hit_vld && int'(hit_set) == s && int'(hit_way) == w && mv[s][w]) begin
          ma[s][w] = 0;
        end else if (mv[s][w]) begin
          ma[s][w] = (ma[s][w] + 1 > MAXA) ? MAXA : ma[s][w] + 1;
        end
      end
  endtask

  // driver: one clock with the currently driven inputs, then check and idle inputs
  task automatic tick();
    logic [2:0] e;
    @(posedge clk);
    if (lookup_vld) exp_q.push_back(model_victim(int'(lookup_set)));
    model_update();
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      held = e;
      chk("victim_vld_pulse", int'(victim_vld), 1);
      chk("victim_way", int'(victim_way), int'(e[1:0]));
      chk("victim_inv", int'(victim_inv), int'(e[2]));
    end else begin
      chk("victim_vld_idle", int'(victim_vld), 0);
      chk("victim_way_hold", int'(victim_way), int'(held[1:0]));
      chk("victim_inv_hold", int'(victim_inv), int'(held[2]));
    end
    lookup_vld = 1'b0;
    fill_vld = 1'b0;
    hit_vld = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_lookup(input int s);
    lookup_vld = 1'b1;
    lookup_set = 2'(s);
    tick();
  endtask

  task automatic do_fill(input int s, input int w);
    fill_vld = 1'b1;
    fill_set = 2'(s);
    fill_way = 2'(w);
    tick();
  endtask

  task automatic fill_set_all(input int s);
    for (int w = 0; w < WAYS; w++) do_fill(s, w);
  endtask

  task automatic rand_phase(input int n, input int fill_div, input int flush_div);
    for (int i = 0; i < n; i++) begin
      lookup_vld = 1'($urandom_range(0, 1));
      lookup_set = 2'($urandom_range(0, 3));
      fill_vld   = ($urandom_range(0, fill_div - 1) == 0);
      fill_set   = 2'($urandom_range(0, 3));
      fill_way   = 2'($urandom_range(0, 3));
      hit_vld    = ($urandom_range(0, 3) == 0);
      hit_set    = 2'($urandom_range(0, 3));
      hit_way    = 2'($urandom_range(0, 3));
      flush      = (flush_div > 0) ? ($urandom_range(0, flush_div - 1) == 0) : 1'b0;
      tick();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_vld"}, int'(victim_vld), 0);
    chk({tag, "_way"}, int'(victim_way), 0);
    chk({tag, "_inv"}, int'(victim_inv), 0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // empty set: free slot way 0
    do_lookup(2);
    chk("empty_set_way", int'(victim_way), 0);
    chk("empty_set_inv", int'(victim_inv), 1);

    // FIFO order, then refill of oldest moves victim to way 1
    fill_set_all(1);
    do_lookup(1);
    chk("fifo_oldest_way", int'(victim_way), 0);
    chk("fifo_oldest_inv", int'(victim_inv), 0);
    do_fill(1, 0);
    do_lookup(1);
    chk("fifo_refill_way", int'(victim_way), 1);

    // all ages saturated: tie goes to way 0, then refill way 0 -> way 1
    fill_set_all(0);
    repeat (300) tick();
    do_lookup(0);
    chk("saturated_tie_way", int'(victim_way), 0);
    do_fill(0, 0);
    do_lookup(0);
    chk("saturated_refill_way", int'(victim_way), 1);

    // hit on oldest way: ignored in FIFO, re-ages in LRU
    fill_set_all(3);
    hit_vld = 1'b1;
    hit_set = 2'd3;
    hit_way = 2'd0;
    tick();
    do_lookup(3);
    chk("hit_policy_way", int'(victim_way), LRU ? 1 : 0);

    // flush beats a same-cycle fill
    fill_set_all(2);
    flush = 1'b1;
    fill_vld = 1'b1;
    fill_set = 2'd2;
    fill_way = 2'd1;
    tick();
    do_lookup(2);
    chk("flush_way", int'(victim_way), 0);
    chk("flush_inv", int'(victim_inv), 1);
    do_fill(2, 0);
    do_lookup(2);
    chk("flush_dropped_fill_way", int'(victim_way), 1);
    chk("flush_dropped_fill_inv", int'(victim_inv), 1);

    // lookup in the same cycle as a fill sees the old state
    lookup_vld = 1'b1;
    lookup_set = 2'd2;
    fill_vld = 1'b1;
    fill_set = 2'd2;
    fill_way = 2'd1;
    tick();
    chk("same_cycle_fill_way", int'(victim_way), 1);

    rand_phase(1500, 8, 200);
    rand_phase(1500, 64, 0);

    // reset the cycle after a lookup: result cancelled, everything invalid
    lookup_vld = 1'b1;
    lookup_set = 2'd1;
    @(posedge clk);
    #1;
    lookup_vld = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs_zero("mid_lookup_reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    for (int s = 0; s < SETS; s++) begin
      do_lookup(s);
      chk("post_reset_inv", int'(victim_inv), 1);
    end

    rand_phase(800, 8, 100);
    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_repl_fifo.md
CACHE_REPL_FIFO -- requirements
Module: cache_repl_fifo

Interface
REQ-001 Parameter SETS, default 4: number of cache sets, >= 2, power of two.
REQ-002 Parameter WAYS, default 4: ways per set, >= 2, power of two.
REQ-003 Parameter CNT_W, default 8: age counter width in bits, >= 2.
REQ-004 Derived widths: SET_W = clog2(SETS), WAY_W = clog2(WAYS).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 lookup_vld  input  1  victim query request for lookup_set.
REQ-008 lookup_set  input  SET_W  set index to query.
REQ-009 fill_vld  input  1  line written into (fill_set, fill_way).
REQ-010 fill_set  input  SET_W  set of fill.
REQ-011 fill_way  input  WAY_W  way of fill.
REQ-012 hit_vld  input  1  read hit on (hit_set, hit_way).
REQ-013 hit_set  input  SET_W; hit_way  input  WAY_W  location of hit.
REQ-014 flush  input  1  invalidate every way of every set.
REQ-015 victim_vld  output  1  victim result valid, one-cycle pulse.
REQ-016 victim_way  output  WAY_W  way to replace in the queried set.
REQ-017 victim_inv  output  1  selected way was invalid (free slot).

Function
REQ-018 State: per (set, way) one valid bit and one CNT_W-bit age counter.
REQ-019 Each cycle, every valid way with no fill that cycle increments its age by 1, saturating at 2^CNT_W-1; invalid ways hold age 0.
REQ-020 Fill: valid set to 1, age cleared to 0 at the next edge.
REQ-021 Victim selection: lowest-index invalid way if any (victim_inv=1); else the way with maximum age, ties to lowest index (victim_inv=0).
REQ-022 Latency: lookup_vld sampled at edge N -> victim_vld=1 with result after edge N, for exactly one cycle; lookups accepted every cycle, no backpressure.
REQ-023 Selection uses state before edge N; a fill/hit/flush in the same cycle is not visible to that lookup.
REQ-024 Priority on the same (set, way) in one cycle: flush > fill > hit.
REQ-025 Flush: all valid bits and ages cleared at the next edge; a simultaneous fill is discarded.
REQ-026 fill_vld or hit_vld at an already-valid way is legal; fill re-ages the way to 0.
REQ-027 victim_way and victim_inv hold their last value while victim_vld=0.

Reset
REQ-028 On rst_n low, immediately: all valid bits 0, all ages 0, victim_vld=0, victim_way=0, victim_inv=0.
REQ-029 Reset asserted mid-lookup cancels the pending result; no victim_vld after release without a new lookup.
REQ-030 First lookup may be issued on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro CACHE_REPL_LRU_EN defined: hit_vld clears the age of (hit_set, hit_way) to 0 if that way is valid (LRU policy).
REQ-032 CACHE_REPL_LRU_EN undefined: hit_vld, hit_set, hit_way are ignored (pure FIFO policy); ports remain present.

Verification (SETS=4, WAYS=4, CNT_W=8)
REQ-033 Reset, lookup set 2 -> next cycle victim_vld=1, victim_way=0, victim_inv=1.
REQ-034 Fill set 1 ways 0,1,2,3 on consecutive cycles, lookup set 1 -> victim_way=0, victim_inv=0; refill way 0, lookup -> victim_way=1.
REQ-035 Fill set 0 ways 0..3, idle 300 cycles (all ages 255), lookup -> victim_way=0 (tie rule).
REQ-036 Fill set 3 ways 0..3, hit way 0, lookup set 3 -> victim_way=0 without CACHE_REPL_LRU_EN, victim_way=1 with it.
REQ-037 Fill set 2 fully, then flush with fill (2,1) same cycle, lookup set 2 -> victim_way=0, victim_inv=1; way 1 remains invalid.
REQ-038 Assert rst_n low the cycle after lookup_vld -> victim_vld stays 0, all outputs 0, all ways invalid.
